// File: rtl/bright_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bright_pkg
// Description : Shared types and constants for the brightness step controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bright_pkg;

  localparam logic [3:0] LEVEL_MIN = 4'h0;
  localparam logic [3:0] LEVEL_MAX = 4'hF;
  localparam logic [3:0] LEVEL_RST = 4'h8;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-FF synchroniser plus stability counter for one active-low
//               key. held_o is the debounced pressed state; press_o pulses
//               for one cycle on each debounced released->pressed change.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic held_o,
  output logic press_o
);

  localparam logic [15:0] C_LAST = 16'(DEBOUNCE_CYC - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        prev_q;
  logic        db_q;     // 1 = pressed
  logic        press_q;
  logic [15:0] cnt_q;

  // Synchronise the raw key, restart the count on any change, commit after a stable run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= 1'b0;
      if (sync2_q != prev_q) begin
        cnt_q <= '0;
      end else if (~sync2_q != db_q) begin
        if (cnt_q == C_LAST) begin
          db_q    <= ~sync2_q;
          press_q <= ~sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign held_o  = db_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/bright_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bright_step_ctrl
// Description : Debounces the up/down keys, arbitrates them against the AE
//               requester and emits at most one inc/dec pulse per frame, one
//               cycle after the vsync rising edge.
//               Optional macro BRIGHT_AUTO_REPEAT_EN adds key auto-repeat
//               counted in frames.
// Revision    : 1.0 - initial release
// ============================================================================
module bright_step_ctrl
  import bright_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 50000
`ifdef BRIGHT_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY = 30,
  parameter int unsigned REPEAT_PER = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       vsync,
  input  logic       ae_valid,
  input  logic       ae_dir,
  output logic       ae_ready,
  input  logic [3:0] level_in,
  output logic       inc,
  output logic       dec,
  output logic       pending
);

  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  logic   vsync_q;

  logic w_up_held, w_up_press;
  logic w_dn_held, w_dn_press;
  logic w_vs_rise;
  logic w_rpt_up, w_rpt_dn;
  logic w_up_ev, w_dn_ev;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_up_n),
    .held_o  (w_up_held),
    .press_o (w_up_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dn (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_dn_n),
    .held_o  (w_dn_held),
    .press_o (w_dn_press)
  );

  assign w_vs_rise = vsync & ~vsync_q;

`ifdef BRIGHT_AUTO_REPEAT_EN
  // Index 0 = up key, 1 = down key; a key only repeats while held on its own.
  logic [1:0] w_alone;
  logic [1:0] w_rpt;

  assign w_alone = {w_dn_held & ~w_up_held, w_up_held & ~w_dn_held};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
    logic [7:0] frm_q;   // saturating count of frames held
    logic [7:0] per_q;   // frames since the last repeat
    logic [7:0] w_frm_nx;

    assign w_frm_nx = (frm_q == 8'hFF) ? frm_q : frm_q + 8'd1;
    assign w_rpt[gi] = w_alone[gi] & w_vs_rise &
                       ((w_frm_nx == 8'(REPEAT_DLY)) |
                        ((frm_q >= 8'(REPEAT_DLY)) & (per_q == 8'(REPEAT_PER - 1))));

    // Count frames while the key is held alone; release or both held clears.
    always_ff @(posedge clk) begin
      if (rst || !w_alone[gi]) begin
        frm_q <= '0;
        per_q <= '0;
      end else if (w_vs_rise) begin
        frm_q <= w_frm_nx;
        per_q <= w_rpt[gi] ? 8'd0 : per_q + 8'd1;
      end
    end
  end

  assign w_rpt_up = w_rpt[0];
  assign w_rpt_dn = w_rpt[1];
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
`endif

  // A press while the other key is held means both are down: ignore it.
  assign w_up_ev = (w_up_press | w_rpt_up) & ~w_dn_held;
  assign w_dn_ev = (w_dn_press | w_rpt_dn) & ~w_up_held;

  // State, latched direction and vsync history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_DN;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      vsync_q <= vsync;
    end
  end

  // Next state, key/AE arbitration and limit-checked step pulses.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    ae_ready = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    pending  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_up_ev || w_dn_ev) begin
          dir_d   = w_up_ev ? DIR_UP : DIR_DN;
          state_d = ARMED;
        end else if (ae_valid) begin
          ae_ready = 1'b1;
          dir_d    = ae_dir ? DIR_UP : DIR_DN;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        pending = 1'b1;
        if (w_vs_rise) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        inc     = (dir_q == DIR_UP) && (level_in < LEVEL_MAX);
        dec     = (dir_q == DIR_DN) && (level_in > LEVEL_MIN);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are held quiet for the whole reset cycle.
    if (rst) begin
      ae_ready = 1'b0;
      inc      = 1'b0;
      dec      = 1'b0;
      pending  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bright_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bright_step_ctrl
// Description : Directed self-checking bench for bright_step_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bright_step_ctrl;

  localparam int unsigned C_DEB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic       vsync = 1'b0;
  logic       ae_valid = 1'b0;
  logic       ae_dir = 1'b0;
  logic       ae_ready;
  logic [3:0] level_in = 4'd8;
  logic       inc;
  logic       dec;
  logic       pending;

  int n_cmp = 0;
  int n_err = 0;
  int n_inc = 0;
  int n_dec = 0;

  bright_step_ctrl #(.DEBOUNCE_CYC(C_DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .vsync    (vsync),
    .ae_valid (ae_valid),
    .ae_dir   (ae_dir),
    .ae_ready (ae_ready),
    .level_in (level_in),
    .inc      (inc),
    .dec      (dec),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (inc) n_inc++;
    if (dec) n_dec++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: vsync high 4 cycles, low 4; reports inc/dec on the cycle after the rise.
  task automatic frame(output logic o_inc, output logic o_dec);
    vsync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_inc = inc;
    o_dec = dec;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    tick(4);
  endtask

  // Hold a key long enough to debounce, then release and let it debounce back.
  task automatic press(input logic up);
    if (up) key_up_n = 1'b0; else key_dn_n = 1'b0;
    tick(2 * C_DEB);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    tick(2 * C_DEB);
  endtask

  initial begin
    logic fi, fd;
    int   base;
    logic exp_i;

    // Reset with idle inputs: everything quiet during and after.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {28'd0, inc, dec, ae_ready, pending}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
    chk("post_rst_outs", {28'd0, inc, dec, ae_ready, pending}, 32'd0);

    // Up key held 2*DEBOUNCE: one inc on the cycle after the vsync rise.
    level_in = 4'd8;
    key_up_n = 1'b0;
    tick(2 * C_DEB);
    chk("up_pending", {31'd0, pending}, 32'd1);
    chk("up_no_early_inc", n_inc, 0);
    key_up_n = 1'b1;
    tick(2 * C_DEB);
    chk("release_keeps_step", {31'd0, pending}, 32'd1);
    frame(fi, fd);
    chk("up_inc_lat", {30'd0, fi, fd}, 32'b10);
    chk("up_inc_count", n_inc, 1);
    chk("up_pending_clr", {31'd0, pending}, 32'd0);

    // Down-key glitch shorter than the debounce window: no effect.
    key_dn_n = 1'b0;
    tick(C_DEB / 2);
    key_dn_n = 1'b1;
    tick(2 * C_DEB);
    chk("glitch_pending", {31'd0, pending}, 32'd0);
    frame(fi, fd);
    chk("glitch_dec", {31'd0, fd}, 32'd0);
    chk("glitch_dec_count", n_dec, 0);

    // AE request coinciding with a key press event: key wins, AE retries.
    base = n_inc;
    key_up_n = 1'b0;
    tick(C_DEB + 3);           // press event is visible in this cycle
    ae_valid = 1'b1;
    ae_dir   = 1'b0;
    @(negedge clk);
    chk("ae_blocked_by_key", {31'd0, ae_ready}, 32'd0);
    key_up_n = 1'b1;
    tick(1);
    chk("ae_armed_pending", {31'd0, pending}, 32'd1);
    chk("ae_armed_not_ready", {31'd0, ae_ready}, 32'd0);
    tick(2);
    vsync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("key_first_inc", {30'd0, inc, dec}, 32'b10);
    @(posedge clk);
    @(negedge clk);
    chk("ae_accepted", {31'd0, ae_ready}, 32'd1);
    @(posedge clk);
    #1 ae_valid = 1'b0;
    vsync = 1'b0;
    chk("ae_pending", {31'd0, pending}, 32'd1);
    tick(2 * C_DEB);
    frame(fi, fd);
    chk("ae_dec", {30'd0, fi, fd}, 32'b01);
    chk("ae_inc_total", n_inc - base, 1);
    chk("ae_dec_total", n_dec, 1);

    // Level limits drop the step; one step inside the range still goes.
    level_in = 4'd15;
    press(1'b1);
    chk("max_pending", {31'd0, pending}, 32'd1);
    frame(fi, fd);
    chk("max_no_inc", {30'd0, fi, fd}, 32'b00);
    chk("max_pending_clr", {31'd0, pending}, 32'd0);
    level_in = 4'd0;
    press(1'b0);
    frame(fi, fd);
    chk("min_no_dec", {30'd0, fi, fd}, 32'b00);
    level_in = 4'd1;
    press(1'b0);
    frame(fi, fd);
    chk("one_dec", {30'd0, fi, fd}, 32'b01);

    // Reset while armed discards the step.
    level_in = 4'd8;
    base = n_inc;
    press(1'b1);
    chk("rst_arm_pending", {31'd0, pending}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pending_gated", {31'd0, pending}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pending_clr", {31'd0, pending}, 32'd0);
    frame(fi, fd);
    chk("rst_no_pulse", {30'd0, fi, fd}, 32'b00);
    chk("rst_inc_total", n_inc - base, 0);

    // Up key held for 50 frames: frame 1 only, plus repeats when enabled.
    key_up_n = 1'b0;
    tick(2 * C_DEB);
    for (int f = 1; f <= 50; f++) begin
      frame(fi, fd);
      exp_i = (f == 1);
`ifdef BRIGHT_AUTO_REPEAT_EN
      exp_i = exp_i || (f == 31) || (f == 39) || (f == 47);
`endif
      chk($sformatf("hold_f%0d", f), {30'd0, fi, fd}, {30'd0, exp_i, 1'b0});
    end
    key_up_n = 1'b1;
    tick(2 * C_DEB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
